alu_cond_stage: RTL

- Execute-stage back end directly downstream of the N-bit ALU.
- Holds the architectural flag register (bits 3..0 = Z N C V, same order as the ALU flags output).
- Evaluates the 4-bit ARM condition field against the stored flags, gates write enables, conditionally updates flags, and registers results into the execute/memory pipeline register.
- Has stall/flush control and saturating executed/annulled counters.

---
 rtl/alu_cond_stage.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/alu_cond_stage.sv
// Execute-stage back end: ARM condition check, flag register,
// gated write enables, EX/MEM pipeline register and perf counters.
//
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   valid_in        : instruction present in execute
//   cond            : ARM condition field
//   set_flags       : S bit, request flag update
//   alu_control     : ALU operation this cycle (0/1 = add/sub)
//   alu_result      : ALU result
//   alu_flags       : ALU flags {Z,N,C,V}
//   rd_in           : destination register
//   reg_write_in    : register write request
//   mem_write_in    : memory write request
//   stall, flush    : hold pipeline register / insert bubble
//   cond_ex         : condition passes for current instruction (comb)
//   flags_q         : architectural flags {Z,N,C,V}
//   valid_out ..    : registered EX/MEM outputs
//   exec_cnt        : executed instruction count (saturating)
//   annul_cnt       : annulled instruction count (saturating)
module alu_cond_stage #(
    parameter int N     = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_in,
    input  logic [3:0]       cond,
    input  logic             set_flags,
    input  logic [3:0]       alu_control,
    input  logic [N-1:0]     alu_result,
    input  logic [3:0]       alu_flags,
    input  logic [3:0]       rd_in,
    input  logic             reg_write_in,
    input  logic             mem_write_in,
    input  logic             stall,
    input  logic             flush,
    output logic             cond_ex,
    output logic [3:0]       flags_q,
    output logic             valid_out,
    output logic [N-1:0]     result_out,
    output logic [3:0]       rd_out,
    output logic             reg_write_out,
    output logic             mem_write_out,
    output logic [CNT_W-1:0] exec_cnt,
    output logic [CNT_W-1:0] annul_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             z, n, c, v;
    logic             cond_pass;
    logic             accept;
    logic             upd_flags;

    logic [3:0]       flags_d;
    logic             valid_q, valid_d;
    logic [N-1:0]     result_q, result_d;
    logic [3:0]       rd_q, rd_d;
    logic             rw_q, rw_d;
    logic             mw_q, mw_d;
    logic [CNT_W-1:0] exec_q, exec_d;
    logic [CNT_W-1:0] annul_q, annul_d;

    // Condition is judged against the stored flags only; flags
    // produced by the current instruction are not bypassed.
    assign {z, n, c, v} = flags_q;

    always_comb begin
        cond_pass = 1'b1;
        case (cond)
            4'b0000: cond_pass = z;
            4'b0001: cond_pass = !z;
            4'b0010: cond_pass = c;
            4'b0011: cond_pass = !c;
            4'b0100: cond_pass = n;
            4'b0101: cond_pass = !n;
            4'b0110: cond_pass = v;
            4'b0111: cond_pass = !v;
            4'b1000: cond_pass = c & !z;
            4'b1001: cond_pass = !c | z;
            4'b1010: cond_pass = (n == v);
            4'b1011: cond_pass = (n != v);
            4'b1100: cond_pass = !z & (n == v);
            4'b1101: cond_pass = z | (n != v);
            default: cond_pass = 1'b1;
        endcase
    end

    assign cond_ex   = valid_in & cond_pass;
    assign accept    = !reset & !stall & !flush;
    assign upd_flags = accept & cond_ex & set_flags;

    always_comb begin
        flags_d = flags_q;
        if (upd_flags) begin
            // Only add/sub produce meaningful carry and overflow;
            // every other op leaves C,V as they were.
            if (alu_control == 4'b0000 || alu_control == 4'b0001)
                flags_d = alu_flags;
            else
                flags_d = {alu_flags[3:2], flags_q[1:0]};
        end
    end

    always_comb begin
        valid_d  = valid_q;
        result_d = result_q;
        rd_d     = rd_q;
        rw_d     = rw_q;
        mw_d     = mw_q;
        if (!stall) begin
            if (flush) begin
                valid_d = 1'b0;
                rw_d    = 1'b0;
                mw_d    = 1'b0;
            end else begin
                valid_d  = valid_in;
                result_d = alu_result;
                rd_d     = rd_in;
                rw_d     = reg_write_in & cond_ex;
                mw_d     = mem_write_in & cond_ex;
            end
        end
    end

    always_comb begin
        exec_d  = exec_q;
        annul_d = annul_q;
        if (accept && valid_in) begin
            if (cond_ex) begin
                if (exec_q != '1)
                    exec_d = exec_q + CNT_ONE;
            end else begin
                if (annul_q != '1)
                    annul_d = annul_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q  <= '0;
            valid_q  <= 1'b0;
            result_q <= '0;
            rd_q     <= '0;
            rw_q     <= 1'b0;
            mw_q     <= 1'b0;
            exec_q   <= '0;
            annul_q  <= '0;
        end else begin
            flags_q  <= flags_d;
            valid_q  <= valid_d;
            result_q <= result_d;
            rd_q     <= rd_d;
            rw_q     <= rw_d;
            mw_q     <= mw_d;
            exec_q   <= exec_d;
            annul_q  <= annul_d;
        end
    end

    assign valid_out     = valid_q;
    assign result_out    = result_q;
    assign rd_out        = rd_q;
    assign reg_write_out = rw_q;
    assign mem_write_out = mw_q;
    assign exec_cnt      = exec_q;
    assign annul_cnt     = annul_q;

endmodule
